// File: rtl/axi4_lite_read_slave_q.sv
// AXI4-Lite read slave with an in-order read-address queue, address window
// decode, backend request timeout and OKAY/SLVERR/DECERR responses.
// One backend request is outstanding at a time; all outputs are registered.
module axi4_lite_read_slave_q #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] ADDR_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0] ADDR_SIZE = 64'h0800_0000,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] AR_ADDR,
    input  logic              AR_VALID,
    output logic              AR_READY,
    output logic [DATA_W-1:0] R_DATA,
    output logic [1:0]        R_RESP,
    output logic              R_VALID,
    input  logic              R_READY,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ERR
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 2);

    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [TW-1:0]   T_LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit              T_EN     = (TIMEOUT != 0);
    // Window bounds carry one extra bit so BASE+SIZE cannot wrap past zero
    localparam logic [ADDR_W:0] WIN_LO   = {1'b0, ADDR_BASE};
    localparam logic [ADDR_W:0] WIN_HI   = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [ADDR_W-1:0] r_q [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ar_ready;
    logic [1:0]        r_state;
    logic [TW-1:0]     r_timer;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head;
    logic              w_in_range;
    logic              w_timeout;
    logic [CW-1:0]     w_count_nxt;

    assign w_push     = AR_VALID & r_ar_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_head     = r_q[r_rptr];
    assign w_in_range = ({1'b0, w_head} >= WIN_LO) && ({1'b0, w_head} < WIN_HI);
    assign w_timeout  = T_EN && (r_timer == T_LAST);

    // Next queue occupancy from this edge's push/pop
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Address queue storage; contents are don't-care until pushed
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q[r_wptr] <= AR_ADDR;
        end
    end

    // Queue pointers, occupancy and registered AR_READY (low during reset)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ar_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count    <= w_count_nxt;
            r_ar_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    // Request/response FSM: pop, decode, backend wait with timeout, R handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_in_range) begin
                            r_mem_addr <= w_head;
                            r_mem_req  <= 1'b1;
                            r_timer    <= '0;
                            r_state    <= S_REQ;
                        end else begin
                            r_data  <= '0;
                            r_resp  <= RESP_DECERR;
                            r_valid <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    // An ack arriving on the timeout edge still returns data
                    if (MEM_ACK) begin
                        r_data    <= MEM_RDATA;
                        r_resp    <= MEM_ERR ? RESP_SLVERR : RESP_OKAY;
                        r_valid   <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else if (w_timeout) begin
                        r_data    <= '0;
                        r_resp    <= RESP_SLVERR;
                        r_valid   <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (R_READY) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AR_READY = r_ar_ready;
    assign R_DATA   = r_data;
    assign R_RESP   = r_resp;
    assign R_VALID  = r_valid;
    assign MEM_REQ  = r_mem_req;
    assign MEM_ADDR = r_mem_addr;

endmodule

// File: tb/tb_axi4_lite_read_slave_q.sv
// Bench for axi4_lite_read_slave_q: directed reads, window boundaries, queue
// back-pressure, timeout, error response, reset abort and random traffic
// checked against an in-order transaction model.
module tb_axi4_lite_read_slave_q;

    localparam int unsigned TMO = 8;

    logic        CLK;
    logic        RST_N;
    logic [63:0] AR_ADDR;
    logic        AR_VALID;
    logic        AR_READY;
    logic [63:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_VALID;
    logic        R_READY;
    logic        MEM_REQ;
    logic [63:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [63:0] MEM_RDATA;
    logic        MEM_ERR;

    int total = 0;
    int bad   = 0;

    axi4_lite_read_slave_q #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .DEPTH     (4),
        .ADDR_BASE (64'h8000_0000),
        .ADDR_SIZE (64'h0800_0000),
        .TIMEOUT   (TMO)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .AR_ADDR   (AR_ADDR),
        .AR_VALID  (AR_VALID),
        .AR_READY  (AR_READY),
        .R_DATA    (R_DATA),
        .R_RESP    (R_RESP),
        .R_VALID   (R_VALID),
        .R_READY   (R_READY),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ERR   (MEM_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- checks ----------------
    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample/drive point: 1 time unit after the rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_window(input logic [63:0] a);
        return (a >= 64'h8000_0000) && (a < 64'h8800_0000);
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 6))
            0, 1, 2: a = 64'h8000_0000 + {32'h0, $urandom_range(0, 32'h07FF_FFFF) & 32'hFFFF_FFF8};
            3:       a = ($urandom_range(0, 1) != 0) ? 64'h87FF_FFF8 : 64'h8800_0000;
            4:       a = {32'h0, $urandom & 32'h7FFF_FFF8};
            5:       a = ($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'h7FFF_FFFF;
            default: a = {$urandom, $urandom};
        endcase
        return a;
    endfunction

    // Single isolated read. dly = backend cycles of MEM_REQ before acking
    // (values past the timeout window mean the backend never answers).
    task automatic do_read(input logic [63:0] addr, input int unsigned dly,
                           input logic [63:0] data, input logic err,
                           input int unsigned hold);
        int unsigned reqc;
        int unsigned lat;
        int unsigned exp_reqc;
        int unsigned exp_lat;
        logic [63:0] ed;
        logic [1:0]  er;
        if (!in_window(addr)) begin
            ed = '0; er = 2'b11; exp_reqc = 0; exp_lat = 1;
        end else if (dly + 1 > TMO) begin
            ed = '0; er = 2'b10; exp_reqc = TMO; exp_lat = TMO + 1;
        end else begin
            ed = data; er = err ? 2'b10 : 2'b00; exp_reqc = dly + 1; exp_lat = dly + 2;
        end
        reqc = 0;
        lat  = 0;
        check1("rd_ar_ready", AR_READY, 1'b1);
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        tick();
        AR_VALID = 1'b0;
        for (int c = 0; c < 40 && !R_VALID; c++) begin
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
            end else if (MEM_REQ) begin
                reqc++;
                check64("rd_mem_addr", MEM_ADDR, addr);
                if (reqc == dly + 1) begin
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = data;
                    MEM_ERR   = err;
                end
            end
            tick();
            lat++;
        end
        MEM_ACK = 1'b0;
        check1("rd_r_valid", R_VALID, 1'b1);
        check_i("rd_latency", int'(lat), int'(exp_lat));
        check_i("rd_req_cycles", int'(reqc), int'(exp_reqc));
        check64("rd_r_data", R_DATA, ed);
        check2("rd_r_resp", R_RESP, er);
        check1("rd_mem_req_low", MEM_REQ, 1'b0);
        for (int unsigned h = 0; h < hold; h++) begin
            tick();
            check1("hold_r_valid", R_VALID, 1'b1);
            check64("hold_r_data", R_DATA, ed);
            check2("hold_r_resp", R_RESP, er);
        end
        R_READY = 1'b1;
        tick();
        R_READY = 1'b0;
        check1("rd_r_valid_drop", R_VALID, 1'b0);
    endtask

    // ---------------- streaming engine (queued traffic) ----------------
    logic [63:0] tosend [$];
    logic [63:0] pend   [$];
    logic [63:0] mreq_q [$];
    logic [63:0] bdata  [$];
    logic        berr   [$];
    logic        prev_arready;
    logic        prev_rvalid;
    int unsigned wcnt;
    int unsigned cur_dly;
    int unsigned dly_max;
    int          rr_mode;
    int          accepted;

    task automatic eng_init();
        tosend.delete(); pend.delete(); mreq_q.delete(); bdata.delete(); berr.delete();
        AR_VALID = 1'b0; R_READY = 1'b0; MEM_ACK = 1'b0;
        wcnt = 0;
        cur_dly = $urandom_range(0, dly_max);
        prev_arready = AR_READY;
        prev_rvalid = 1'b0;
        accepted = 0;
    endtask

    task automatic eng_cycle();
        logic [63:0] a;
        logic        rr;
        // AR handshake on the edge just passed
        if (AR_VALID && prev_arready) begin
            a = tosend.pop_front();
            pend.push_back(a);
            if (in_window(a)) mreq_q.push_back(a);
            accepted++;
        end
        // Backend: one request at a time, answered after cur_dly cycles
        if (MEM_ACK) begin
            MEM_ACK = 1'b0;
        end else if (MEM_REQ) begin
            check_i("eng_req_expected", (mreq_q.size() > 0) ? 1 : 0, 1);
            if (mreq_q.size() > 0) check64("eng_mem_addr", MEM_ADDR, mreq_q[0]);
            if (wcnt == cur_dly) begin
                if (mreq_q.size() > 0) void'(mreq_q.pop_front());
                MEM_RDATA = {$urandom, $urandom};
                MEM_ERR   = ($urandom_range(0, 3) == 0);
                MEM_ACK   = 1'b1;
                bdata.push_back(MEM_RDATA);
                berr.push_back(MEM_ERR);
                wcnt    = 0;
                cur_dly = $urandom_range(0, dly_max);
            end else begin
                wcnt++;
            end
        end
        // R channel: held response must persist; contents follow issue order
        if (prev_rvalid && !R_READY) check1("eng_r_held", R_VALID, 1'b1);
        if (rr_mode == 0)      rr = 1'b0;
        else if (rr_mode == 2) rr = 1'b1;
        else                   rr = ($urandom_range(0, 3) != 0);
        if (R_VALID) begin
            check_i("eng_r_expected", (pend.size() > 0) ? 1 : 0, 1);
            if (pend.size() > 0) begin
                if (in_window(pend[0])) begin
                    check_i("eng_bresp_avail", (bdata.size() > 0) ? 1 : 0, 1);
                    if (bdata.size() > 0) begin
                        check64("eng_r_data", R_DATA, bdata[0]);
                        check2("eng_r_resp", R_RESP, berr[0] ? 2'b10 : 2'b00);
                    end
                end else begin
                    check64("eng_r_data_dec", R_DATA, 64'h0);
                    check2("eng_r_resp_dec", R_RESP, 2'b11);
                end
                if (rr) begin
                    if (in_window(pend[0]) && bdata.size() > 0) begin
                        void'(bdata.pop_front());
                        void'(berr.pop_front());
                    end
                    void'(pend.pop_front());
                end
            end
        end
        R_READY     = rr;
        prev_rvalid = R_VALID;
        if (tosend.size() > 0) begin
            AR_VALID = 1'b1;
            AR_ADDR  = tosend[0];
        end else begin
            AR_VALID = 1'b0;
        end
        prev_arready = AR_READY;
    endtask

    task automatic eng_drain(input int bound, input string tag);
        int done;
        done = 0;
        for (int c = 0; c < bound && done == 0; c++) begin
            tick();
            eng_cycle();
            if (tosend.size() == 0 && pend.size() == 0) done = 1;
        end
        check_i(tag, done, 1);
        tick();
        R_READY = 1'b0; AR_VALID = 1'b0; MEM_ACK = 1'b0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST_N = 1'b0; AR_ADDR = '0; AR_VALID = 1'b0; R_READY = 1'b0;
        MEM_ACK = 1'b0; MEM_RDATA = '0; MEM_ERR = 1'b0;
        dly_max = 0; rr_mode = 0;

        // Reset values
        tick(); tick();
        check1("rst_ar_ready", AR_READY, 1'b0);
        check1("rst_r_valid", R_VALID, 1'b0);
        check64("rst_r_data", R_DATA, 64'h0);
        check2("rst_r_resp", R_RESP, 2'b00);
        check1("rst_mem_req", MEM_REQ, 1'b0);
        check64("rst_mem_addr", MEM_ADDR, 64'h0);
        RST_N = 1'b1;
        check1("rel_ar_ready_before_edge", AR_READY, 1'b0);
        tick();
        check1("rel_ar_ready_after_edge", AR_READY, 1'b1);

        // 1: basic read, ack after 2 further cycles of MEM_REQ
        do_read(64'h8000_0010, 2, 64'hDEAD_BEEF, 1'b0, 0);
        // 2: decode errors and window boundaries
        do_read(64'h0000_1000, 0, 64'h1111, 1'b0, 0);
        do_read(64'h87FF_FFF8, 1, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
        do_read(64'h8800_0000, 0, 64'h2222, 1'b0, 0);
        do_read(64'h8000_0000, 0, 64'h3333, 1'b0, 0);
        do_read(64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h4444, 1'b0, 0);

        // 4: timeout, ack on the timeout edge, then stray ack while idle
        do_read(64'h8000_0100, 100, 64'h5555, 1'b0, 0);
        MEM_ACK = 1'b1; MEM_RDATA = 64'hBAD0_BAD0; MEM_ERR = 1'b0;
        tick();
        MEM_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check1("stray_ack_no_rvalid", R_VALID, 1'b0);
            check1("stray_ack_no_req", MEM_REQ, 1'b0);
            tick();
        end
        do_read(64'h8000_0108, TMO - 1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0);

        // 5: backend error response held for 6 cycles
        do_read(64'h8000_0200, 1, 64'hCAFE_F00D, 1'b1, 6);

        // 3: back-pressure. One read parks in the response stage, four fill
        // the queue, the sixth address stalls until responses drain.
        dly_max = 0; rr_mode = 0;
        eng_init();
        for (int i = 0; i < 6; i++) tosend.push_back(64'h8000_1000 + 64'(i * 8));
        eng_cycle();
        for (int c = 0; c < 15; c++) begin
            tick();
            eng_cycle();
        end
        check_i("bp_accepted", accepted, 5);
        check1("bp_ar_ready_low", AR_READY, 1'b0);
        check_i("bp_stalled", tosend.size(), 1);
        check1("bp_r_valid", R_VALID, 1'b1);
        rr_mode = 2;
        eng_drain(200, "bp_drain");
        check_i("bp_all_accepted", accepted, 6);

        // Random traffic against the in-order model
        dly_max = 5; rr_mode = 1;
        eng_init();
        for (int i = 0; i < 60; i++) tosend.push_back(rand_addr());
        eng_cycle();
        eng_drain(3000, "rand_drain");
        check_i("rand_accepted", accepted, 60);

        // 6: reset while in REQ with two entries queued
        AR_VALID = 1'b1; AR_ADDR = 64'h8000_3000;
        tick();
        AR_ADDR = 64'h8000_3008;
        tick();
        AR_ADDR = 64'h8000_3010;
        tick();
        AR_VALID = 1'b0;
        check1("mid_req_active", MEM_REQ, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check1("async_mem_req_drop", MEM_REQ, 1'b0);
        check1("async_r_valid_low", R_VALID, 1'b0);
        check1("async_ar_ready_low", AR_READY, 1'b0);
        tick();
        RST_N = 1'b1;
        MEM_ACK = 1'b1; MEM_RDATA = 64'hDEAD_DEAD; MEM_ERR = 1'b0;
        tick();
        MEM_ACK = 1'b0;
        check1("post_rst_ar_ready", AR_READY, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check1("post_rst_no_rvalid", R_VALID, 1'b0);
            check1("post_rst_no_req", MEM_REQ, 1'b0);
            tick();
        end
        do_read(64'h8000_0400, 0, 64'h7777_8888, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
